// File: rtl/exe_mem_wb_stage_if.sv
// Signal bundle between the EXE stage and the EXE/MEM/WB back end.
// The master side drives the EXE results and pipeline control; the slave side is the stage itself.
interface exe_mem_wb_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic [DATA_W-1:0]  aluout;
  logic [DATA_W-1:0]  rdata2_ID_EXE;
  logic [RADDR_W-1:0] waddr_out_ID_EXE;
  logic               regwrite_ID_EXE;
  logic               memread_ID_EXE;
  logic               memwrite_ID_EXE;
  logic               stall;
  logic               flush;

  logic [DATA_W-1:0]  aluout_EXE_MEM;
  logic [RADDR_W-1:0] waddr_EXE_MEM;
  logic               regwrite_EXE_MEM;
  logic [DATA_W-1:0]  wdata_MEM_WB;
  logic [RADDR_W-1:0] waddr_MEM_WB;
  logic               wen_MEM_WB;
  logic               addr_err;

  modport master (
    output aluout, rdata2_ID_EXE, waddr_out_ID_EXE, regwrite_ID_EXE,
           memread_ID_EXE, memwrite_ID_EXE, stall, flush,
    input  aluout_EXE_MEM, waddr_EXE_MEM, regwrite_EXE_MEM,
           wdata_MEM_WB, waddr_MEM_WB, wen_MEM_WB, addr_err
  );

  modport slave (
    input  aluout, rdata2_ID_EXE, waddr_out_ID_EXE, regwrite_ID_EXE,
           memread_ID_EXE, memwrite_ID_EXE, stall, flush,
    output aluout_EXE_MEM, waddr_EXE_MEM, regwrite_EXE_MEM,
           wdata_MEM_WB, waddr_MEM_WB, wen_MEM_WB, addr_err
  );
endinterface

// File: rtl/exe_mem_wb_stage.sv
// EXE/MEM and MEM/WB pipeline registers with a word-addressed data memory.
// Exports the registered destinations for forwarding and drives the register-file write port.
module exe_mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DMEM_AW = 8
) (
  input logic             clk,
  input logic             rst,
  exe_mem_wb_stage_if.slave bus
);
  localparam int DEPTH = 1 << DMEM_AW;

  logic [DATA_W-1:0]  aluout_q;
  logic [DATA_W-1:0]  sdata_q;
  logic [RADDR_W-1:0] waddr_q;
  logic               regwrite_q;
  logic               memread_q;
  logic               memwrite_q;

  logic [DATA_W-1:0]  wdata_q;
  logic [RADDR_W-1:0] waddr_wb_q;
  logic               wen_q;
  logic               addr_err_q;

  logic [DATA_W-1:0]  dmem [DEPTH];
  logic               addr_ok;
  logic [DMEM_AW-1:0] idx;
  logic [DATA_W-1:0]  load_data;

  // Byte address must be word aligned and fall inside the memory.
  assign addr_ok   = (aluout_q[1:0] == 2'b00) && (aluout_q[DATA_W-1:DMEM_AW+2] == '0);
  assign idx       = aluout_q[DMEM_AW+1:2];
  assign load_data = addr_ok ? dmem[idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluout_q   <= '0;
      sdata_q    <= '0;
      waddr_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (bus.flush) begin
      aluout_q   <= '0;
      sdata_q    <= '0;
      waddr_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (!bus.stall) begin
      aluout_q   <= bus.aluout;
      sdata_q    <= bus.rdata2_ID_EXE;
      waddr_q    <= bus.waddr_out_ID_EXE;
      regwrite_q <= bus.regwrite_ID_EXE;
      memread_q  <= bus.memread_ID_EXE;
      memwrite_q <= bus.memwrite_ID_EXE;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (memwrite_q && addr_ok && !bus.stall)
      dmem[idx] <= sdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_q    <= '0;
      waddr_wb_q <= '0;
      wen_q      <= 1'b0;
    end else if (!bus.stall) begin
      wdata_q    <= memread_q ? load_data : aluout_q;
      waddr_wb_q <= waddr_q;
      wen_q      <= regwrite_q && (waddr_q != '0) && !(memread_q && !addr_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      addr_err_q <= 1'b0;
    else if ((memread_q || memwrite_q) && !addr_ok && !bus.stall)
      addr_err_q <= 1'b1;
  end

  assign bus.aluout_EXE_MEM   = aluout_q;
  assign bus.waddr_EXE_MEM    = waddr_q;
  assign bus.regwrite_EXE_MEM = regwrite_q;
  assign bus.wdata_MEM_WB     = wdata_q;
  assign bus.waddr_MEM_WB     = waddr_wb_q;
  assign bus.wen_MEM_WB       = wen_q;
  assign bus.addr_err         = addr_err_q;
endmodule

// File: tb/tb_exe_mem_wb_stage.sv
// Scoreboard bench: an instruction-level model predicts every cycle's outputs, a monitor compares.
// Memory is modelled as a plain word array indexed by byte address / 4.
module tb_exe_mem_wb_stage;
  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        mw;
  } ins_t;

  typedef struct {
    logic [31:0] alu_em;
    logic [4:0]  wa_em;
    logic        rw_em;
    logic [31:0] wdata;
    logic [4:0]  wa_wb;
    logic        wen;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exe_mem_wb_stage_if #(.DATA_W(32), .RADDR_W(5)) bus ();

  exe_mem_wb_stage #(.DATA_W(32), .RADDR_W(5), .DMEM_AW(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  logic [31:0] mem_m [DEPTH];
  ins_t        occ;
  logic [31:0] m_wdata;
  logic [4:0]  m_waddr;
  logic        m_wen;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] sd,
                              input logic [4:0] wa, input logic rw,
                              input logic mr, input logic mw);
    ins_t i;
    i.alu = alu; i.sd = sd; i.wa = wa; i.rw = rw; i.mr = mr; i.mw = mw;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic model_reset();
    occ     = bubble();
    m_wdata = '0;
    m_waddr = '0;
    m_wen   = 1'b0;
    m_err   = 1'b0;
  endtask

  // Drive one cycle's inputs and predict what the next rising edge produces.
  task automatic step(input ins_t in, input logic st, input logic fl);
    bit   ok;
    exp_t e;
    bus.aluout           = in.alu;
    bus.rdata2_ID_EXE    = in.sd;
    bus.waddr_out_ID_EXE = in.wa;
    bus.regwrite_ID_EXE  = in.rw;
    bus.memread_ID_EXE   = in.mr;
    bus.memwrite_ID_EXE  = in.mw;
    bus.stall            = st;
    bus.flush            = fl;
    if (!st) begin
      ok = (occ.alu % 4 == 0) && (occ.alu < 4 * DEPTH);
      if (occ.mr) m_wdata = ok ? mem_m[occ.alu / 4] : 32'h0;
      else        m_wdata = occ.alu;
      m_waddr = occ.wa;
      m_wen   = occ.rw && (occ.wa != 0) && !(occ.mr && !ok);
      if ((occ.mr || occ.mw) && !ok) m_err = 1'b1;
      if (occ.mw && ok) mem_m[occ.alu / 4] = occ.sd;
    end
    if (fl)       occ = bubble();
    else if (!st) occ = in;
    e.alu_em = occ.alu; e.wa_em = occ.wa; e.rw_em = occ.rw;
    e.wdata = m_wdata; e.wa_wb = m_waddr; e.wen = m_wen; e.err = m_err;
    sbq.push_back(e);
  endtask

  task automatic cyc(input ins_t in, input logic st, input logic fl);
    @(negedge clk);
    step(in, st, fl);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aluout_em"}, bus.aluout_EXE_MEM, 32'h0);
    chk({tag, "_waddr_em"}, {27'h0, bus.waddr_EXE_MEM}, 32'h0);
    chk({tag, "_regwrite_em"}, {31'h0, bus.regwrite_EXE_MEM}, 32'h0);
    chk({tag, "_wdata_wb"}, bus.wdata_MEM_WB, 32'h0);
    chk({tag, "_waddr_wb"}, {27'h0, bus.waddr_MEM_WB}, 32'h0);
    chk({tag, "_wen_wb"}, {31'h0, bus.wen_MEM_WB}, 32'h0);
    chk({tag, "_addr_err"}, {31'h0, bus.addr_err}, 32'h0);
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("aluout_EXE_MEM", bus.aluout_EXE_MEM, e.alu_em);
        chk("waddr_EXE_MEM", {27'h0, bus.waddr_EXE_MEM}, {27'h0, e.wa_em});
        chk("regwrite_EXE_MEM", {31'h0, bus.regwrite_EXE_MEM}, {31'h0, e.rw_em});
        chk("wdata_MEM_WB", bus.wdata_MEM_WB, e.wdata);
        chk("waddr_MEM_WB", {27'h0, bus.waddr_MEM_WB}, {27'h0, e.wa_wb});
        chk("wen_MEM_WB", {31'h0, bus.wen_MEM_WB}, {31'h0, e.wen});
        chk("addr_err", {31'h0, bus.addr_err}, {31'h0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic ins_t rand_ins();
    int          k;
    logic [31:0] a;
    k = $urandom_range(0, 19);
    a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    if (k == 19) a = (($urandom_range(0, 1) == 0) ? (a | 32'h1) : (a | 32'h0000_0400));
    if (k < 8)       return mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0);
    else if (k < 13) return mk(a, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0);
    else if (k < 17) return mk(a, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1);
    else             return mk(a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                               k == 19, k != 19);
  endfunction

  task automatic random_phase(input int n);
    logic st, fl;
    for (int i = 0; i < n; i++) begin
      st = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 9) == 0);
      cyc(rand_ins(), st, fl);
    end
  endtask

  initial begin
    ins_t ld;
    bus.aluout = '0; bus.rdata2_ID_EXE = '0; bus.waddr_out_ID_EXE = '0;
    bus.regwrite_ID_EXE = 1'b0; bus.memread_ID_EXE = 1'b0; bus.memwrite_ID_EXE = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    step(bubble(), 1'b0, 1'b0);

    // Give every memory word a known value.
    for (int i = 0; i < DEPTH; i++)
      cyc(mk(32'(i * 4), $urandom, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);

    // ALU op into r3.
    cyc(mk(32'h1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    // Store then load the same word on the next cycle.
    cyc(mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    cyc(mk(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    // Misaligned load, then out-of-range store, then read back 0x0 region.
    cyc(mk(32'h13, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    cyc(mk(32'h400, 32'hBAD0BAD0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    cyc(mk(32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    // Store to 0x20 held for three stalled cycles, then loaded back.
    cyc(mk(32'h20, 32'hCAFE0020, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    ld = mk(32'h20, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ld, 1'b1, 1'b0);
    cyc(ld, 1'b0, 1'b0);
    cyc(mk(32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    // Flushed store must not reach memory.
    cyc(mk(32'h08, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
    cyc(mk(32'h08, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    // Flush and stall together: bubble enters, MEM/WB holds.
    cyc(mk(32'h77, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
    cyc(bubble(), 1'b0, 1'b0);
    cyc(bubble(), 1'b0, 1'b0);

    random_phase(300);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(mk(32'h99, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc(mk(32'hAB, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);

    random_phase(300);
    cyc(bubble(), 1'b0, 1'b0);
    cyc(bubble(), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
